// File: rtl/alu_muldiv_unit_pkg.sv
// Shared types for the RV32M iterative multiply/divide unit.
package riscv_md_pkg;

  // funct3 encodings of the M extension (funct7 = FUNCT7_MULDIV)
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  // IDLE encodes as zero so the reset value is the idle state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/alu_muldiv_unit_if.sv
// Request/response bus between the EX control path and the mul/div unit.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload stable until that
// edge; ready may change freely. Request side: in_valid/in_ready with
// funct3/op_a/op_b. Response side: out_valid/out_ready with result.
interface alu_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, funct3, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, funct3, op_a, op_b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/alu_muldiv_unit_md_step.sv
// One iteration of the shared datapath: retires BITS_PER_CYCLE bits of
// either an unsigned shift-add multiply or an unsigned restoring divide.
//  multiply: hi = partial product high half, lo = remaining multiplier
//            bits (product low half shifts in from the top), opb = multiplicand
//  divide:   hi = partial remainder, lo = dividend shifting out / quotient
//            shifting in, opb = divisor
module md_step #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opb,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [XLEN:0]   w_wide;

  // Unrolled bit-serial steps, BITS_PER_CYCLE of them per call
  always_comb begin
    w_hi   = i_hi;
    w_lo   = i_lo;
    w_wide = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (i_is_div) begin
        // remainder stays below the divisor, so one extra bit is enough
        w_wide = {w_hi, w_lo[XLEN-1]};
        w_lo   = {w_lo[XLEN-2:0], 1'b0};
        if (w_wide >= {1'b0, i_opb}) begin
          w_wide  = w_wide - {1'b0, i_opb};
          w_lo[0] = 1'b1;
        end
        w_hi = w_wide[XLEN-1:0];
      end else begin
        w_wide = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_opb} : {(XLEN+1){1'b0}});
        w_lo   = {w_wide[0], w_lo[XLEN-1:1]};
        w_hi   = w_wide[XLEN:1];
      end
    end
    o_hi = w_hi;
    o_lo = w_lo;
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operates on magnitudes and applies
// sign correction and half-select in the final iteration; divide-by-zero
// and signed overflow bypass the iteration and complete in one cycle.
module alu_muldiv_unit
  import riscv_md_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  alu_muldiv_unit_if.slave    bus,
  output md_state_e           o_dbg_state
);

  localparam int N_ITER = XLEN / BITS_PER_CYCLE;
  localparam int CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  md_state_e       r_state;
  md_op_e          r_op;
  logic            r_is_div;
  logic            r_sa;
  logic            r_sb;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opb;
  logic [CW-1:0]   r_iter;
  logic [XLEN-1:0] r_result;
  logic            r_out_valid;

  md_op_e            w_op;
  logic              w_is_div;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_div_zero;
  logic              w_ovf;
  logic [XLEN-1:0]   w_fast_res;
  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  // Request decode: operand signedness, magnitudes and the fast-path cases
  always_comb begin
    w_op       = md_op_e'(bus.funct3);
    w_is_div   = bus.funct3[2];
    w_sa       = bus.op_a[XLEN-1] &
                 ((w_op == MD_MULH) || (w_op == MD_MULHSU) || (w_op == MD_DIV) || (w_op == MD_REM));
    w_sb       = bus.op_b[XLEN-1] &
                 ((w_op == MD_MULH) || (w_op == MD_DIV) || (w_op == MD_REM));
    w_mag_a    = w_sa ? (~bus.op_a + 1'b1) : bus.op_a;
    w_mag_b    = w_sb ? (~bus.op_b + 1'b1) : bus.op_b;
    w_div_zero = w_is_div && (bus.op_b == '0);
    w_ovf      = ((w_op == MD_DIV) || (w_op == MD_REM)) &&
                 (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
    // funct3[1] separates REM/REMU from DIV/DIVU
    w_fast_res = '0;
    if (w_div_zero) begin
      w_fast_res = bus.funct3[1] ? bus.op_a : '1;
    end else if (w_ovf) begin
      w_fast_res = bus.funct3[1] ? '0 : bus.op_a;
    end
  end

  md_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .i_is_div (r_is_div),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_opb    (r_opb),
    .o_hi     (w_hi),
    .o_lo     (w_lo)
  );

  // Sign fix-up and half select on the last step's output
  always_comb begin
    w_prod  = (r_sa ^ r_sb) ? (~{w_hi, w_lo} + 1'b1) : {w_hi, w_lo};
    w_quo   = (r_sa ^ r_sb) ? (~w_lo + 1'b1) : w_lo;
    w_rem   = r_sa ? (~w_hi + 1'b1) : w_hi;
    w_final = '0;
    case (r_op)
      MD_MUL:                        w_final = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  w_final = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               w_final = w_quo;
      MD_REM, MD_REMU:               w_final = w_rem;
      default:                       w_final = '0;
    endcase
  end

  // Control FSM with datapath registers; flush wins over everything but reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= MD_MUL;
      r_is_div    <= 1'b0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opb       <= '0;
      r_iter      <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_op     <= w_op;
            r_is_div <= w_is_div;
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_iter   <= '0;
            if (w_div_zero || w_ovf) begin
              r_result    <= w_fast_res;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_hi    <= '0;
              r_lo    <= w_is_div ? w_mag_a : w_mag_b;
              r_opb   <= w_is_div ? w_mag_b : w_mag_a;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_hi   <= w_hi;
          r_lo   <= w_lo;
          r_iter <= r_iter + CW'(1);
          if (r_iter == CW'(N_ITER - 1)) begin
            r_result    <= w_final;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench: three instances (1, 2 and 4 bits per cycle) receive the
// same stimulus; each result and latency is compared to hand-computed values.
module tb_alu_muldiv_unit;
  import riscv_md_pkg::*;

  localparam int XLEN = 32;
  localparam int NDUT = 3;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_ready;

  logic            ov    [NDUT];
  logic            ir    [NDUT];
  logic            bsy   [NDUT];
  logic [XLEN-1:0] res_w [NDUT];
  md_state_e       st_w  [NDUT];

  int errors = 0;
  int checks = 0;
  logic [XLEN-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT instances ----------------
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    alu_muldiv_unit_if #(.XLEN(XLEN)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.funct3    = funct3;
    assign bus.op_a      = op_a;
    assign bus.op_b      = op_b;
    assign bus.out_ready = out_ready;
    assign ov[g]    = bus.out_valid;
    assign ir[g]    = bus.in_ready;
    assign bsy[g]   = bus.busy;
    assign res_w[g] = bus.result;

    alu_muldiv_unit #(
      .XLEN           (XLEN),
      .BITS_PER_CYCLE (1 << g)
    ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .bus         (bus),
      .o_dbg_state (st_w[g])
    );
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [31:0] exp_res);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("%s_ov_b%0d", tag, 1 << d), 32'(ov[d]), 32'd0);
      check($sformatf("%s_ir_b%0d", tag, 1 << d), 32'(ir[d]), 32'd1);
      check($sformatf("%s_busy_b%0d", tag, 1 << d), 32'(bsy[d]), 32'd0);
      check($sformatf("%s_st_b%0d", tag, 1 << d), 32'(st_w[d]), 32'(IDLE));
      check($sformatf("%s_res_b%0d", tag, 1 << d), res_w[d], exp_res);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one request for a single cycle; all instances are idle here.
  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3   = f3;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Wait for out_valid on every instance; latency counts the negedges after
  // the accept edge, so a fast-path result shows a latency of 1.
  task automatic wait_all(output int lat[NDUT], output logic [31:0] res[NDUT]);
    bit seen [NDUT];
    int k;
    k = 0;
    for (int d = 0; d < NDUT; d++) begin
      seen[d] = 1'b0;
      lat[d]  = -1;
      res[d]  = 'x;
    end
    while (!(seen[0] && seen[1] && seen[2]) && k < 80) begin
      @(negedge clk);
      k++;
      for (int d = 0; d < NDUT; d++) begin
        if (!seen[d] && ov[d]) begin
          seen[d] = 1'b1;
          lat[d]  = k;
          res[d]  = res_w[d];
        end
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit fast);
    int lat [NDUT];
    logic [31:0] res [NDUT];
    logic [31:0] e;
    exp_q.push_back(exp);
    send(f3, a, b);
    wait_all(lat, res);
    e = exp_q.pop_front();
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("%s_res_b%0d", tag, 1 << d), res[d], e);
      check($sformatf("%s_lat_b%0d", tag, 1 << d), 32'(lat[d]),
            fast ? 32'd1 : 32'((XLEN >> d) + 1));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat [NDUT];
    logic [31:0] res [NDUT];
    int bad [NDUT];
    int seen_ov;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    funct3    = 3'b000;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset", 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // arithmetic vectors
    run_op("mul_7_m3",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op("mulhu_ff",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op("mulh_ff",       3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    run_op("mulhsu_ff",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_100_7",    3'b101, 32'd100,       32'd7,         32'd14,        1'b0);
    run_op("remu_100_7",    3'b111, 32'd100,       32'd7,         32'd2,         1'b0);
    run_op("div_20_m6",     3'b100, 32'd20,        32'hFFFF_FFFA, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_20_m6",     3'b110, 32'd20,        32'hFFFF_FFFA, 32'd2,         1'b0);
    run_op("div_5_0",       3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1);
    run_op("rem_5_0",       3'b110, 32'd5,         32'd0,         32'd5,         1'b1);
    run_op("divu_5_0",      3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1);
    run_op("div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);

    // backpressure: result held, no new accept while DONE
    out_ready = 1'b0;
    send(3'b101, 32'd100, 32'd7);
    wait_all(lat, res);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("bp_res_b%0d", 1 << d), res[d], 32'd14);
      bad[d] = 0;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (res_w[d] !== 32'd14 || ir[d] !== 1'b0 || ov[d] !== 1'b1 || st_w[d] !== DONE) bad[d]++;
      end
    end
    for (int d = 0; d < NDUT; d++)
      check($sformatf("bp_hold_b%0d", 1 << d), 32'(bad[d]), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check_idle("bp_release", 32'd14);

    // flush in the fifth CALC cycle: no result, previous result kept
    send(3'b000, 32'd7, 32'hFFFF_FFFD);
    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++)
      check($sformatf("flush_pre_st_b%0d", 1 << d), 32'(st_w[d]), 32'(CALC));
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check_idle("flush_calc", 32'd14);

    // flush together with a request: the request is dropped
    flush    = 1'b1;
    in_valid = 1'b1;
    funct3   = 3'b101;
    op_a     = 32'd9;
    op_b     = 32'd3;
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    seen_ov = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) if (ov[d] || bsy[d]) seen_ov++;
    end
    check("flush_req_dropped", 32'(seen_ov), 32'd0);
    check_idle("flush_req", 32'd14);

    // asynchronous reset twelve cycles into an operation
    out_ready = 1'b0;
    send(3'b100, 32'hFFFF_FFF9, 32'd2);
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("rst_pre_busy_b1", 32'(bsy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle("rst_mid", 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen_ov = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) if (ov[d]) seen_ov++;
    end
    check("rst_no_output", 32'(seen_ov), 32'd0);
    check_idle("rst_after", 32'h0);

    run_op("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
